// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction field positions, field widths and the
// fetch-stage state encoding.
package mips_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned JADDR_W  = 26;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_MSB     = 15;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_MSB  = 10;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;
  localparam int unsigned JADDR_MSB  = 25;
  localparam int unsigned JADDR_LSB  = 0;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StValid = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Wait-cycle counter for the fetch stage. Clears when a fetch is accepted,
// counts WAIT cycles without mem_ready, and flags expiry on the cycle whose
// count would reach TIMEOUT_CYCLES.
module fetch_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expire
);

  localparam int unsigned CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LimitM1 = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CntW-1:0] Limit = CntW'(LimitM1);

  logic [CntW-1:0] r_count;

  // Count stalled WAIT cycles; restart on every accepted fetch.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count) begin
      r_count <= r_count + CntW'(1);
    end
  end

  // Expiry only qualifies a stalled cycle, so mem_ready on the limit cycle wins.
  assign o_expire = i_count && (r_count == Limit);

endmodule

// File: rtl/instruction_fetch_register.sv
// Multicycle-MIPS fetch stage and instruction register. Issues one word read
// per accepted fetch_start, latches the returned word and splits it into
// decoded fields. Optional wait timeout is compiled in with FETCH_TIMEOUT_EN.
module instruction_fetch_register
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                fetch_start,
  input  logic [31:0]         pc,
  output logic                mem_req,
  output logic [31:0]         mem_addr,
  input  logic                mem_ready,
  input  logic [31:0]         mem_rdata,
  output logic [INSTR_W-1:0]  instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [REG_W-1:0]    rs,
  output logic [REG_W-1:0]    rt,
  output logic [REG_W-1:0]    rd,
  output logic [REG_W-1:0]    shamt,
  output logic [FUNCT_W-1:0]  funct,
  output logic [IMM_W-1:0]    imm16,
  output logic [JADDR_W-1:0]  jaddr,
  output logic                instr_valid,
  output logic                busy,
  output logic                fetch_error
);

  fetch_state_e       r_state;
  logic [29:0]        r_pc_word;
  logic               r_mem_req;
  logic [INSTR_W-1:0] r_instr;
  logic               r_instr_valid;

  logic w_accept;
  logic w_timeout;
  logic w_unused_pc;

  // Byte offset is dropped silently; fetches are always word reads.
  assign w_unused_pc = ^pc[1:0];

  // A new fetch can start from IDLE or directly out of VALID (back-to-back).
  assign w_accept = fetch_start && ((r_state == StIdle) || (r_state == StValid));

`ifdef FETCH_TIMEOUT_EN
  logic r_fetch_error;

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clock  (clock),
    .i_reset_n(reset_n),
    .i_clear  (w_accept),
    .i_count  ((r_state == StWait) && !mem_ready),
    .o_expire (w_timeout)
  );

  // Sticky error: set on timeout, cleared by the next accepted fetch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_error <= 1'b0;
    end else if (w_accept) begin
      r_fetch_error <= 1'b0;
    end else if (w_timeout) begin
      r_fetch_error <= 1'b1;
    end
  end

  assign fetch_error = r_fetch_error;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
  assign fetch_error      = 1'b0;
`endif

  // Fetch FSM with registered request, instruction and valid pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= StIdle;
      r_pc_word     <= '0;
      r_mem_req     <= 1'b0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      r_instr_valid <= 1'b0;
      case (r_state)
        StIdle, StValid: begin
          if (fetch_start) begin
            r_pc_word <= pc[31:2];
            r_mem_req <= 1'b1;
            r_state   <= StWait;
          end else begin
            r_state   <= StIdle;
          end
        end
        StWait: begin
          if (mem_ready) begin
            r_instr       <= mem_rdata;
            r_instr_valid <= 1'b1;
            r_mem_req     <= 1'b0;
            r_state       <= StValid;
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_state   <= StIdle;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= StIdle;
        end
      endcase
    end
  end

  assign mem_req     = r_mem_req;
  assign busy        = r_mem_req;
  assign mem_addr    = {r_pc_word, 2'b00};
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;

  // Field split is pure slicing of the instruction register.
  assign opcode = r_instr[OPCODE_MSB:OPCODE_LSB];
  assign rs     = r_instr[RS_MSB:RS_LSB];
  assign rt     = r_instr[RT_MSB:RT_LSB];
  assign rd     = r_instr[RD_MSB:RD_LSB];
  assign shamt  = r_instr[SHAMT_MSB:SHAMT_LSB];
  assign funct  = r_instr[FUNCT_MSB:FUNCT_LSB];
  assign imm16  = r_instr[IMM_MSB:IMM_LSB];
  assign jaddr  = r_instr[JADDR_MSB:JADDR_LSB];

endmodule
